// File: rtl/fixed_point_pkg.sv
// Shared constants and state encoding for the decimal fixed-point divider.
// Result encoding: X +/- Y/10^5, with X=256 meaning "-0.Y".
package fixed_point_pkg;

  localparam int FRAC_SCALE = 100000;
  localparam int FRAC_BITS  = 17;
  localparam int NEG_ZERO_X = 256;
  localparam int X_SAT      = 255;
  localparam int Y_SAT      = 99999;

  typedef enum logic [2:0] {
    IDLE,
    INT,
    MUL,
    FRAC,
    DONE
  } state_t;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module restoring_div_step #(
  parameter int W = 21
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] sh;

  always_comb begin
    sh      = {rem_in, bit_in};
    q_bit   = (sh >= {1'b0, divisor});
    rem_out = q_bit ? W'(sh - {1'b0, divisor}) : sh[W-1:0];
  end

endmodule

// File: rtl/int_div_int_fixed_point.sv
// Sequential signed divider producing a decimal fixed-point quotient.
// One shared restoring step serves the integer and fractional phases.
module int_div_int_fixed_point #(
  parameter int INT_W      = 21,
  parameter int FRAC_SCALE = 100000,
  parameter int FRAC_BITS  = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [INT_W-1:0] num,
  input  logic [INT_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [9:0]       fixed_X,
  output logic [17:0]      fixed_Y,
  output logic             overflow
);

  import fixed_point_pkg::*;

  localparam int P_W = INT_W + FRAC_BITS;

  state_t               state;
  logic [INT_W-1:0]     acc;
  logic [INT_W-1:0]     dvs;
  logic [INT_W-1:0]     rem;
  logic [FRAC_BITS-1:0] fsh;
  logic                 neg;
  logic                 dz;
  logic [4:0]           cnt;

  logic [INT_W-1:0]     num_mag;
  logic [INT_W-1:0]     den_mag;
  logic                 step_bit;
  logic                 q_bit;
  logic [INT_W-1:0]     rem_nx;
  logic [P_W-1:0]       prod;
  logic                 sat;
  logic [9:0]           x_nx;

  restoring_div_step #(
    .W(INT_W)
  ) u_step (
    .rem_in (rem),
    .bit_in (step_bit),
    .divisor(dvs),
    .rem_out(rem_nx),
    .q_bit  (q_bit)
  );

  // acc holds the dividend, then the integer quotient through FRAC/DONE
  always_comb begin
    num_mag  = num[INT_W-1] ? -num : num;
    den_mag  = den[INT_W-1] ? -den : den;
    step_bit = (state == FRAC) ? fsh[FRAC_BITS-1]
                               : acc[INT_W-1];
    prod     = P_W'(rem) * P_W'(FRAC_SCALE);
    sat      = dz || (acc > INT_W'(X_SAT));
    x_nx     = acc[9:0];
    if (sat) begin
      x_nx = neg ? -10'(X_SAT) : 10'(X_SAT);
    end else if (neg) begin
      if (acc == '0 && fsh != '0)
        x_nx = 10'(NEG_ZERO_X);
      else
        x_nx = -acc[9:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      fixed_X  <= '0;
      fixed_Y  <= '0;
      overflow <= 1'b0;
      acc      <= '0;
      dvs      <= '0;
      rem      <= '0;
      fsh      <= '0;
      neg      <= 1'b0;
      dz       <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc   <= num_mag;
            dvs   <= den_mag;
            rem   <= '0;
            neg   <= num[INT_W-1] ^ den[INT_W-1];
            dz    <= (den == '0);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= INT;
          end
        end
        INT: begin
          acc <= {acc[INT_W-2:0], q_bit};
          rem <= rem_nx;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(INT_W - 1)) begin
            cnt   <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          rem   <= prod[P_W-1:FRAC_BITS];
          fsh   <= prod[FRAC_BITS-1:0];
          state <= FRAC;
        end
        FRAC: begin
          fsh <= {fsh[FRAC_BITS-2:0], q_bit};
          rem <= rem_nx;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(FRAC_BITS - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          fixed_X  <= x_nx;
          fixed_Y  <= sat ? 18'(Y_SAT) : 18'(fsh);
          overflow <= sat;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_div_int_fixed_point.sv
// Scoreboard bench: reference model pushes expected results, a monitor
// pops and compares on every done pulse.
module tb_int_div_int_fixed_point;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [20:0] num;
  logic [20:0] den;
  logic        busy;
  logic        done;
  logic [9:0]  fixed_X;
  logic [17:0] fixed_Y;
  logic        overflow;

  typedef struct {
    int x;
    int y;
    bit ov;
    int n;
    int d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  int_div_int_fixed_point dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .num     (num),
    .den     (den),
    .busy    (busy),
    .done    (done),
    .fixed_X (fixed_X),
    .fixed_Y (fixed_Y),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int n, input int d);
    exp_t e;
    longint an, ad, q, f;
    bit neg;
    an  = (n < 0) ? -n : n;
    ad  = (d < 0) ? -d : d;
    neg = (n < 0) ^ (d < 0);
    e.n = n;
    e.d = d;
    if (ad == 0 || an / ad > 255) begin
      e.ov = 1'b1;
      e.x  = neg ? -255 : 255;
      e.y  = 99999;
    end else begin
      q    = an / ad;
      f    = ((an % ad) * 100000) / ad;
      e.ov = 1'b0;
      e.y  = int'(f);
      if (!neg)                 e.x = int'(q);
      else if (q == 0 && f != 0) e.x = 256;
      else                      e.x = -int'(q);
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no result");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("x(%0d/%0d)", e.n, e.d),
              int'($signed(fixed_X)), e.x);
        check($sformatf("y(%0d/%0d)", e.n, e.d),
              int'(fixed_Y), e.y);
        check($sformatf("ov(%0d/%0d)", e.n, e.d),
              int'(overflow), int'(e.ov));
      end
    end
  end

  // issue one division; optionally retrigger start mid-flight
  task automatic do_div(input int n, input int d, input bit poke);
    int cyc;
    exp_q.push_back(model(n, d));
    start = 1'b1;
    num   = 21'(n);
    den   = 21'(d);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    cyc = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 10) begin
        start = 1'b1;
        num   = 21'(-12345);
        den   = 21'(7);
      end else if (poke && cyc == 11) begin
        start = 1'b0;
      end
      if (cyc < 40 && !done && busy !== 1'b1) begin
        checks++;
        fails++;
        $display("FAIL busy_low: got busy=%0b expected 1 at cycle %0d",
                 busy, cyc);
      end
    end
    check("latency", cyc, 40);
    check("busy_in_done", int'(busy), 0);
  endtask

  initial begin
    int rn, rd;
    reset = 1'b1;
    start = 1'b0;
    num   = '0;
    den   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x", int'(fixed_X), 0);
    check("rst_y", int'(fixed_Y), 0);
    check("rst_ov", int'(overflow), 0);
    reset = 1'b0;
    @(negedge clk);

    do_div(7, 2, 0);
    do_div(-1, 3, 0);
    do_div(-7, 2, 0);
    do_div(6, -3, 0);
    do_div(5, 0, 0);
    do_div(100000, 3, 0);
    do_div(0, -9, 0);
    do_div(-1048576, -4096, 0);
    do_div(-1048576, -4112, 0);
    do_div(1048575, 1, 0);
    do_div(-1048576, 1048575, 0);
    do_div(255, 1, 0);
    do_div(-5, 0, 0);
    do_div(22, 7, 1);

    // reset in the middle of a division
    start = 1'b1;
    num   = 21'(1000);
    den   = 21'(7);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_x", int'(fixed_X), 0);
    check("midrst_y", int'(fixed_Y), 0);
    check("midrst_ov", int'(overflow), 0);
    repeat (45) @(negedge clk);
    do_div(1000, 7, 0);

    for (int i = 0; i < 30; i++) begin
      rn = int'($signed(21'($urandom))) >>> $urandom_range(0, 10);
      rd = int'($signed(21'($urandom))) >>> $urandom_range(3, 20);
      if (i % 10 == 9) rd = 0;
      do_div(rn, rd, 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
